multi_clk_gen: RTL and testbench

Parametrised multi-channel programmable clock generator for the correlator timing chain. It produces NCH independent square waves from one system clock. Each channel has a nanosecond half-period, a start-phase offset and a per-channel enable. A global sync strobe realigns all channels. Fractional-period remainders carry across toggles, so average frequency is exact. Each channel also provides a toggle strobe and a rising-edge counter.

---
 rtl/multi_clk_gen_if.sv | 25 ++
 rtl/multi_clk_gen.sv | 130 +++++++++++++
 tb/tb_multi_clk_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multi_clk_gen_if.sv
// Control and output bundle for the multi-channel clock generator.
// Per-channel fields are packed channel-major: channel i at [i*W +: W].
interface multi_clk_gen_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       enable;
  logic [NCH*WIDTH-1:0] half_ns;
  logic [NCH*WIDTH-1:0] phase_ns;
  logic                 sync;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH*CNT_W-1:0] rise_cnt;

  modport master (
    output enable, half_ns, phase_ns, sync,
    input  clk_out, tick, rise_cnt
  );

  modport slave (
    input  enable, half_ns, phase_ns, sync,
    output clk_out, tick, rise_cnt
  );
endinterface

// File: rtl/multi_clk_gen.sv
// NCH programmable square-wave generators stepped STEP ns per clk, with phase offset,
// fractional remainder carry, global sync realign, toggle strobe and rise counter.
module multi_clk_gen #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  multi_clk_gen_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, PHASE, RUN} state_t;

  state_t             state_q [NCH];
  state_t             state_d [NCH];
  logic [WIDTH-1:0]   acc_q   [NCH];
  logic [WIDTH-1:0]   acc_d   [NCH];
  logic [WIDTH-1:0]   half_q  [NCH];
  logic [WIDTH-1:0]   half_d  [NCH];
  logic [WIDTH-1:0]   phase_q [NCH];
  logic [WIDTH-1:0]   phase_d [NCH];
  logic [CNT_W-1:0]   cnt_q   [NCH];
  logic [CNT_W-1:0]   cnt_d   [NCH];
  logic [NCH-1:0]     clk_q, clk_d;
  logic [NCH-1:0]     tick_q, tick_d;
  logic [NCH*CNT_W-1:0] cnt_flat;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        acc_q[i]   <= '0;
        half_q[i]  <= '0;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        acc_q[i]   <= acc_d[i];
        half_q[i]  <= half_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [WIDTH:0]   nxt;
      logic [WIDTH-1:0] half_in;
      logic [WIDTH-1:0] phase_in;
      logic             fast;
      nxt        = {1'b0, acc_q[i]} + (WIDTH+1)'(STEP);
      half_in    = bus.half_ns[i*WIDTH +: WIDTH];
      phase_in   = bus.phase_ns[i*WIDTH +: WIDTH];
      fast       = ({1'b0, half_q[i]} <= (WIDTH+1)'(STEP));
      state_d[i] = state_q[i];
      acc_d[i]   = acc_q[i];
      half_d[i]  = half_q[i];
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];

      // sync outranks both enable changes and any toggle due this cycle
      if (bus.sync) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        acc_d[i]  = '0;
        state_d[i] = IDLE;
        if (bus.enable[i]) begin
          half_d[i]  = half_in;
          phase_d[i] = phase_in;
          state_d[i] = (phase_in != '0) ? PHASE : RUN;
        end
      end else if (!bus.enable[i]) begin
        state_d[i] = IDLE;
        clk_d[i]   = 1'b0;
        acc_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            half_d[i]  = half_in;
            phase_d[i] = phase_in;
            acc_d[i]   = '0;
            state_d[i] = (phase_in != '0) ? PHASE : RUN;
          end
          PHASE: begin
            if (nxt >= {1'b0, phase_q[i]}) begin
              acc_d[i]   = WIDTH'(nxt - {1'b0, phase_q[i]});
              state_d[i] = RUN;
            end else begin
              acc_d[i] = nxt[WIDTH-1:0];
            end
          end
          RUN: begin
            if (fast || nxt >= {1'b0, half_q[i]}) begin
              clk_d[i]  = ~clk_q[i];
              tick_d[i] = 1'b1;
              // remainder carries so the long-run frequency stays exact
              acc_d[i]  = fast ? '0 : WIDTH'(nxt - {1'b0, half_q[i]});
              half_d[i] = half_in;
              if (!clk_q[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
              acc_d[i] = nxt[WIDTH-1:0];
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NCH; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign bus.clk_out  = clk_q;
  assign bus.tick     = tick_q;
  assign bus.rise_cnt = cnt_flat;

endmodule

// File: tb/tb_multi_clk_gen.sv
// Bench for multi_clk_gen: directed timing scenarios plus random traffic, all cycles
// checked against an absolute-time deadline model of each channel.
module tb_multi_clk_gen;
  localparam int NCH = 4, WIDTH = 32, STEP = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_clk_gen_if #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  multi_clk_gen #(.NCH(NCH), .WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, failures = 0, cyc = 0;

  // model: mode 0 idle, 1 waiting out phase, 2 running; T = ns elapsed since start,
  // D = absolute ns at which the next toggle is due
  int     md [NCH];
  longint tt [NCH], dl [NCH], hs [NCH], ph [NCH];
  bit     mclk [NCH], mtick [NCH];
  int     mcnt [NCH];

  int tick_cnt [NCH];
  int first_rise [NCH];
  logic [NCH-1:0] prev_out;
  int tk [8];
  int tk_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint half_in(int i);
    return longint'(bus.half_ns[i*WIDTH +: WIDTH]);
  endfunction

  function automatic longint phase_in(int i);
    return longint'(bus.phase_ns[i*WIDTH +: WIDTH]);
  endfunction

  task automatic m_start(int i);
    hs[i] = half_in(i);
    ph[i] = phase_in(i);
    tt[i] = 0;
    mclk[i] = 0;
    if (ph[i] != 0) md[i] = 1;
    else begin md[i] = 2; dl[i] = hs[i]; end
  endtask

  task automatic m_toggle(int i);
    mclk[i] = !mclk[i];
    mtick[i] = 1;
    if (mclk[i]) mcnt[i] = (mcnt[i] + 1) % (1 << CNT_W);
  endtask

  task automatic model_update();
    for (int i = 0; i < NCH; i++) begin
      mtick[i] = 0;
      if (reset) begin
        md[i] = 0; mclk[i] = 0; mcnt[i] = 0;
      end else if (bus.sync) begin
        mcnt[i] = 0; mclk[i] = 0;
        if (bus.enable[i]) m_start(i); else md[i] = 0;
      end else if (!bus.enable[i]) begin
        md[i] = 0; mclk[i] = 0;
      end else if (md[i] == 0) begin
        m_start(i);
      end else if (md[i] == 1) begin
        tt[i] += STEP;
        if (tt[i] >= ph[i]) begin md[i] = 2; dl[i] = ph[i] + hs[i]; end
      end else begin
        tt[i] += STEP;
        if (hs[i] <= STEP) begin
          m_toggle(i); hs[i] = half_in(i); dl[i] = tt[i] + hs[i];
        end else if (tt[i] >= dl[i]) begin
          m_toggle(i); hs[i] = half_in(i); dl[i] = dl[i] + hs[i];
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] ec, et;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = mclk[i];
      et[i] = mtick[i];
    end
    check("clk_out", bus.clk_out, ec);
    check("tick", bus.tick, et);
    for (int i = 0; i < NCH; i++)
      check($sformatf("rise_cnt%0d", i), bus.rise_cnt[i*CNT_W +: CNT_W], mcnt[i]);
    for (int i = 0; i < NCH; i++) begin
      if (bus.tick[i]) tick_cnt[i]++;
      if (bus.clk_out[i] && !prev_out[i] && first_rise[i] < 0) first_rise[i] = cyc;
    end
    if (bus.tick[0] && tk_n < 8) begin tk[tk_n] = cyc; tk_n++; end
    prev_out = bus.clk_out;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NCH; i++) begin tick_cnt[i] = 0; first_rise[i] = -1; end
    tk_n = 0;
  endtask

  task automatic set_ch(int i, int half, int phase);
    bus.half_ns[i*WIDTH +: WIDTH]  = WIDTH'(half);
    bus.phase_ns[i*WIDTH +: WIDTH] = WIDTH'(phase);
  endtask

  initial begin
    int base, s;
    bit seen;
    reset = 1'b1;
    bus.sync = 1'b0;
    bus.enable = '0;
    bus.half_ns = '0;
    bus.phase_ns = '0;
    prev_out = '0;
    clear_stats();
    step(); step();
    check("rst_clk", bus.clk_out, 0);
    check("rst_cnt", bus.rise_cnt, 0);

    // half=10/phase 0, half=10/phase 4, half=5, half=1 all started on one edge
    reset = 1'b0;
    set_ch(0, 10, 0); set_ch(1, 10, 4); set_ch(2, 5, 0); set_ch(3, 1, 0);
    bus.enable = 4'hf;
    clear_stats();
    step();
    base = cyc;
    repeat (100) step();
    check("rise_ph0", 64'(first_rise[0] - base), 5);
    check("rise_ph4", 64'(first_rise[1] - base), 7);
    check("tog_half5", tick_cnt[2], 40);
    check("tog_half1", tick_cnt[3], 100);
    check("cnt_ch0", bus.rise_cnt[0 +: CNT_W], 10);

    // sync restart, then shorten ch0 half-period part way through its first half
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("sync_clk", bus.clk_out, 0);
    check("sync_tick", bus.tick, 0);
    check("sync_cnt", bus.rise_cnt, 0);
    s = cyc;
    clear_stats();
    step(); step();
    set_ch(0, 6, 0);
    repeat (20) step();
    check("hc_ntick", 64'(tk_n >= 3), 1);
    if (tk_n >= 3) begin
      check("hc_first", 64'(tk[0] - s), 5);
      check("hc_second", 64'(tk[1] - tk[0]), 3);
      check("hc_third", 64'(tk[2] - tk[1]), 3);
    end

    // drop enable while ch0 is high
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      seen = bus.clk_out[0];
    end
    check("dis_seen_high", 64'(seen), 1);
    bus.enable[0] = 1'b0;
    step();
    check("dis_clk", bus.clk_out[0], 0);

    reset = 1'b1;
    step();
    check("rst2_clk", bus.clk_out, 0);
    check("rst2_tick", bus.tick, 0);
    check("rst2_cnt", bus.rise_cnt, 0);
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      bus.sync = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 39) == 0) bus.enable[i] = ~bus.enable[i];
        if ($urandom_range(0, 29) == 0)
          set_ch(i, int'($urandom_range(1, 14)), int'($urandom_range(0, 9)));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
